// File: rtl/decrypt_dispatch_ctrl.sv
// Front-end scheduler for the Caesar/Scytale/ZigZag decryption engines.
// Optional build macro LEN_LIMIT_EN: caps payload length at MAX_LEN and injects a terminator.
module decrypt_dispatch_ctrl #(
  parameter int               DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] TERM   = 8'hFA,
  parameter int               MAX_LEN = 64,
  parameter int               CNT_W   = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        busy_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        select_o,
  output logic              msg_done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  msg_cnt_o
);

`ifdef LEN_LIMIT_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_FWD, S_DRAIN, S_INJECT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_FWD, S_DRAIN} state_t;
`endif

  state_t      state_reg;
  logic        xfer;
  logic        is_term;
  logic [1:0]  hdr_sel;
  logic [3:0]  busy_ext;
`ifdef LEN_LIMIT_EN
  logic [LEN_W-1:0] len_cnt_reg;
`endif

  // Select code 3 has no engine behind it; treat it as never busy so the
  // illegal-select path does not depend on an out-of-range index.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_busy
      assign busy_ext[gi] = busy_i[gi];
    end
  endgenerate
  assign busy_ext[3] = 1'b0;

  assign xfer    = valid_i && ready_o;
  assign is_term = (data_i == TERM);
  assign hdr_sel = data_i[1:0];

  always_comb begin
    ready_o = 1'b0;
    case (state_reg)
      S_IDLE, S_FWD, S_DRAIN: ready_o = 1'b1;
      default:                ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      data_o      <= '0;
      valid_o     <= 1'b0;
      select_o    <= 2'd0;
      msg_done_o  <= 1'b0;
      err_o       <= 1'b0;
      msg_cnt_o   <= '0;
`ifdef LEN_LIMIT_EN
      len_cnt_reg <= '0;
`endif
    end else begin
      valid_o    <= 1'b0;
      msg_done_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // Header byte: only the select field matters, it is never forwarded.
          if (xfer) begin
            select_o <= hdr_sel;
`ifdef LEN_LIMIT_EN
            len_cnt_reg <= '0;
`endif
            if (hdr_sel == 2'd3) begin
              err_o     <= 1'b1;
              state_reg <= S_DRAIN;
            end else if (busy_ext[hdr_sel]) begin
              state_reg <= S_HOLD;
            end else begin
              state_reg <= S_FWD;
            end
          end
        end
        S_HOLD: begin
          if (!busy_ext[select_o]) state_reg <= S_FWD;
        end
        S_FWD: begin
          if (xfer) begin
            data_o  <= data_i;
            valid_o <= 1'b1;
            if (is_term) begin
              msg_done_o <= 1'b1;
              msg_cnt_o  <= msg_cnt_o + 1'b1;
              state_reg  <= S_IDLE;
            end
`ifdef LEN_LIMIT_EN
            else begin
              len_cnt_reg <= len_cnt_reg + 1'b1;
              if (len_cnt_reg == LEN_W'(MAX_LEN - 1)) state_reg <= S_INJECT;
            end
`endif
          end
        end
`ifdef LEN_LIMIT_EN
        S_INJECT: begin
          // Close the engine's message ourselves, then swallow the rest upstream.
          data_o     <= TERM;
          valid_o    <= 1'b1;
          msg_done_o <= 1'b1;
          err_o      <= 1'b1;
          msg_cnt_o  <= msg_cnt_o + 1'b1;
          state_reg  <= S_DRAIN;
        end
`endif
        S_DRAIN: begin
          if (xfer && is_term) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
